iecdrv_head_tracker: RTL and testbench
======================================

Name: iecdrv_head_tracker

Overview:
- Parametrised head-position and track-writeback controller for the disk-drive cores (1541 successor; also serves 1571/8250-class double-sided drives).
- Decodes the 2-bit stepper phase from the drive logic into a half-track position and tracks head side.
- Records track modifications and emits queued save requests to the SD track loader through a req/ack handshake, replacing the single toggle strobe.

Parameters:
- MAX_HTRACK, 84, highest legal half-track index; position saturates here.
- RESET_HTRACK, 36, half-track position after reset.
- SIDES, 1, number of heads (1 or 2); with 1, side input is ignored and side output is 0.
- SAVE_Q, 2, depth of the save-request queue (power of 2, >=1).
- HT_W, $clog2(MAX_HTRACK+1), width of half-track fields.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  drive clock enable; stepper sampling and activity qualify on ce.
- stp  in  2  stepper phase from drive logic.
- mtr  in  1  spindle motor on.
- act  in  1  drive activity (LED) from drive logic.
- side_sel  in  1  requested head side (double-sided drives).
- we  in  1  GCR write strobe; marks current track dirty.
- img_mounted  in  1  image-mount level; rising edge = media change.
- htrack  out  HT_W  current half-track position, registered.
- side  out  1  current head side.
- tr00_sense_n  out  1  low when htrack==0.
- save_req  out  1  save request valid (queue head).
- save_htrack  out  HT_W  half-track to save, valid with save_req.
- save_side  out  1  side to save, valid with save_req.
- save_ack  in  1  loader accepted the head entry.
- q_count  out  $clog2(SAVE_Q+1)  number of queued entries.
- overflow  out  1  sticky: a save was dropped because the queue was full.

Behaviour:
- Reset: htrack=RESET_HTRACK, side=0, tr00_sense_n=(RESET_HTRACK!=0), dirty=0, queue empty, save_req=0, q_count=0, overflow=0, stp_old=0.
- Step decode, only on a ce cycle: move = stp - stp_old (mod 4); stp_old<=stp every ce cycle.
  - If mtr and move==01: htrack+1, saturating at MAX_HTRACK.
  - If mtr and move==11: htrack-1, saturating at 0.
  - move==10 (phase skip) and move==00: no motion.
  - Motor off: stp_old still tracks stp, so no motion occurs.
- htrack updates the cycle after the qualifying ce sample; tr00_sense_n is combinational from htrack.
- Side: if SIDES==2, side<=side_sel each ce cycle; otherwise side is fixed 0.
- Dirty: set on any we cycle and cleared by a flush.
- Flush triggers, checked in this priority, at most one per cycle:
  - (a) step actually moves htrack while dirty;
  - (b) side changes while dirty;
  - (c) dirty and act==0.
- Flush: enqueue {htrack, side} as they were before the move/side change, and clear dirty the same cycle.
  - If the queue is full, drop the entry, set overflow, and still clear dirty.
  - A we in the same cycle as a flush re-sets dirty; it is attributed to the new position.
- Queue: FIFO with SAVE_Q entries.
  - save_req = (q_count!=0); save_htrack/save_side show the head entry.
  - save_ack with save_req pops the head, effective next cycle.
  - save_ack without save_req is ignored.
  - A simultaneous push and pop keeps q_count unchanged.
  - When full, a push together with a pop is accepted; no overflow.
- Media change (rising edge of img_mounted, edge-detected with one register):
  - dirty cleared, queue flushed (q_count=0, save_req=0), overflow cleared;
  - htrack is not changed.
- Reset mid-handshake: everything returns to reset values immediately (async). The loader must treat save_req falling without an ack as abort.

Test Plan:
- Reset, then with mtr=1 drive stp 0->1->2->3->0 on ce cycles -> htrack 36->37->38->39->40; with mtr=0 the same sequence leaves htrack=36.
- Step down repeatedly past the bottom (htrack=1, stp 1->0 twice) -> htrack=0, tr00_sense_n=0, no wrap. Step up at MAX_HTRACK=84 -> stays 84.
- Pulse we at htrack 40, then step up -> save_req=1, save_htrack=40, save_side=0, htrack=41. save_ack one cycle -> save_req=0, q_count=0.
- With save_ack held low, cause three dirty step flushes at 40, 41, 42 (SAVE_Q=2) -> q_count=2, overflow=1, entries 40 then 41 delivered in order on successive acks.
- Jump stp 0->2 with mtr=1 -> htrack unchanged. Dirty with act falling -> one save of the current track.
- SIDES=2: dirty on side 0 at htrack 20, toggle side_sel -> save {20,0}, side=1. Then img_mounted rising with an entry pending -> save_req=0, q_count=0, overflow=0.

Source files
------------

// File: rtl/iecdrv_head_tracker.sv
// Stepper-phase to half-track decoder with head side tracking and a queued track-writeback request path.
// Position/side register one cycle after the ce sample; save requests are held in a SAVE_Q-deep FIFO until acked.
module iecdrv_head_tracker #(
    parameter int MAX_HTRACK   = 84,
    parameter int RESET_HTRACK = 36,
    parameter int SIDES        = 1,
    parameter int SAVE_Q       = 2,
    parameter int HT_W         = $clog2(MAX_HTRACK + 1),
    localparam int CNT_W       = $clog2(SAVE_Q + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [1:0]       stp,
    input  logic             mtr,
    input  logic             act,
    input  logic             side_sel,
    input  logic             we,
    input  logic             img_mounted,
    output logic [HT_W-1:0]  htrack,
    output logic             side,
    output logic             tr00_sense_n,
    output logic             save_req,
    output logic [HT_W-1:0]  save_htrack,
    output logic             save_side,
    input  logic             save_ack,
    output logic [CNT_W-1:0] q_count,
    output logic             overflow
);

    localparam int PTR_W = (SAVE_Q > 1) ? $clog2(SAVE_Q) : 1;
    localparam logic [HT_W-1:0]  HT_MAX   = HT_W'(MAX_HTRACK);
    localparam logic [HT_W-1:0]  HT_RST   = HT_W'(RESET_HTRACK);
    localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(SAVE_Q);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SAVE_Q - 1);

    logic [HT_W-1:0]  htrack_q, htrack_d;
    logic             side_q, side_d;
    logic [1:0]       stp_old_q, stp_old_d;
    logic             dirty_q, dirty_d;
    logic             mnt_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [HT_W:0]    mem_q [SAVE_Q];

    logic [1:0] move;
    logic       step_up, step_dn, side_chg, media_chg;
    logic       flush, full, push, pop, drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        move      = stp - stp_old_q;
        step_up   = ce && mtr && (move == 2'd1) && (htrack_q != HT_MAX);
        step_dn   = ce && mtr && (move == 2'd3) && (htrack_q != '0);
        stp_old_d = ce ? stp : stp_old_q;

        htrack_d = htrack_q;
        if (step_up) begin
            htrack_d = htrack_q + 1'b1;
        end else if (step_dn) begin
            htrack_d = htrack_q - 1'b1;
        end

        side_d = side_q;
        if (SIDES == 2 && ce) begin
            side_d = side_sel;
        end
        side_chg  = (side_d != side_q);
        media_chg = img_mounted && !mnt_q;

        // Every trigger enqueues the same pre-change {htrack, side}, so one entry covers them all.
        flush = dirty_q && (step_up || step_dn || side_chg || !act);
        pop   = save_ack && (cnt_q != '0);
        full  = (cnt_q == Q_FULL);
        push  = flush && !media_chg && (!full || pop);
        drop  = flush && !media_chg && full && !pop;

        dirty_d = dirty_q;
        if (media_chg) begin
            dirty_d = 1'b0;
        end else if (we) begin
            dirty_d = 1'b1;
        end else if (flush) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            htrack_q  <= HT_RST;
            side_q    <= 1'b0;
            stp_old_q <= 2'd0;
            dirty_q   <= 1'b0;
            mnt_q     <= 1'b0;
        end else begin
            htrack_q  <= htrack_d;
            side_q    <= side_d;
            stp_old_q <= stp_old_d;
            dirty_q   <= dirty_d;
            mnt_q     <= img_mounted;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < SAVE_Q; i++) begin
                mem_q[i] <= '0;
            end
        end else if (media_chg) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {htrack_q, side_q};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign htrack       = htrack_q;
    assign side         = side_q;
    assign tr00_sense_n = (htrack_q != '0);
    assign save_req     = (cnt_q != '0);
    assign save_htrack  = mem_q[rd_ptr_q][HT_W:1];
    assign save_side    = mem_q[rd_ptr_q][0];
    assign q_count      = cnt_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_iecdrv_head_tracker.sv
// Directed bench for iecdrv_head_tracker (double-sided, 2-entry save queue): vector table plus saturation and reset sequences.
module tb_iecdrv_head_tracker;

    localparam int HT_W  = 7;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             ce, mtr, act, side_sel, we, img_mounted, save_ack;
    logic [1:0]       stp;
    logic [HT_W-1:0]  htrack, save_htrack;
    logic             side, tr00_sense_n, save_req, save_side, overflow;
    logic [CNT_W-1:0] q_count;

    int checks   = 0;
    int failures = 0;
    logic [1:0] cur_stp;

    iecdrv_head_tracker #(
        .MAX_HTRACK(84), .RESET_HTRACK(36), .SIDES(2), .SAVE_Q(2)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .stp(stp), .mtr(mtr), .act(act),
        .side_sel(side_sel), .we(we), .img_mounted(img_mounted),
        .htrack(htrack), .side(side), .tr00_sense_n(tr00_sense_n),
        .save_req(save_req), .save_htrack(save_htrack), .save_side(save_side),
        .save_ack(save_ack), .q_count(q_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ce, mtr;
        logic [1:0] stp;
        logic       we, act, ack, ss, img;
        int         ht;
        logic       side, req;
        int         qc;
        logic       ovf;
        int         sht;
        logic       ssd;
    } vec_t;

    vec_t tv [38];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_step(input logic [1:0] d, input logic w);
        @(negedge clk);
        cur_stp  = cur_stp + d;
        ce = 1'b1; mtr = 1'b1; stp = cur_stp; we = w; act = 1'b1;
        save_ack = 1'b0; side_sel = 1'b0; img_mounted = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          ce mtr stp we act ack ss img  ht side req qc ovf sht ssd
        tv[0]  = '{1, 1, 2'd1, 0, 1, 0, 0, 0, 37, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 1, 2'd2, 0, 1, 0, 0, 0, 38, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{1, 1, 2'd3, 0, 1, 0, 0, 0, 39, 0, 0, 0, 0, 0, 0};
        tv[3]  = '{1, 1, 2'd0, 0, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 1, 2'd1, 0, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{1, 0, 2'd1, 0, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{1, 0, 2'd2, 0, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{1, 0, 2'd3, 0, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[8]  = '{1, 0, 2'd0, 0, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[9]  = '{0, 1, 2'd0, 1, 1, 0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        tv[10] = '{1, 1, 2'd1, 0, 1, 0, 0, 0, 41, 0, 1, 1, 0, 40, 0};
        tv[11] = '{0, 1, 2'd1, 0, 1, 1, 0, 0, 41, 0, 0, 0, 0, 0, 0};
        tv[12] = '{0, 1, 2'd1, 1, 1, 0, 0, 0, 41, 0, 0, 0, 0, 0, 0};
        tv[13] = '{1, 1, 2'd2, 1, 1, 0, 0, 0, 42, 0, 1, 1, 0, 41, 0};
        tv[14] = '{1, 1, 2'd3, 1, 1, 0, 0, 0, 43, 0, 1, 2, 0, 41, 0};
        tv[15] = '{1, 1, 2'd0, 0, 1, 0, 0, 0, 44, 0, 1, 2, 1, 41, 0};
        tv[16] = '{0, 1, 2'd0, 0, 1, 1, 0, 0, 44, 0, 1, 1, 1, 42, 0};
        tv[17] = '{0, 1, 2'd0, 0, 1, 1, 0, 0, 44, 0, 0, 0, 1, 0, 0};
        tv[18] = '{0, 1, 2'd0, 0, 1, 1, 0, 0, 44, 0, 0, 0, 1, 0, 0};
        tv[19] = '{1, 1, 2'd2, 0, 1, 0, 0, 0, 44, 0, 0, 0, 1, 0, 0};
        tv[20] = '{0, 1, 2'd2, 1, 1, 0, 0, 0, 44, 0, 0, 0, 1, 0, 0};
        tv[21] = '{0, 1, 2'd2, 0, 0, 0, 0, 0, 44, 0, 1, 1, 1, 44, 0};
        tv[22] = '{0, 1, 2'd2, 0, 0, 0, 0, 0, 44, 0, 1, 1, 1, 44, 0};
        tv[23] = '{0, 1, 2'd2, 0, 1, 1, 0, 0, 44, 0, 0, 0, 1, 0, 0};
        tv[24] = '{0, 1, 2'd2, 0, 1, 0, 0, 1, 44, 0, 0, 0, 0, 0, 0};
        tv[25] = '{0, 1, 2'd2, 1, 1, 0, 0, 1, 44, 0, 0, 0, 0, 0, 0};
        tv[26] = '{1, 1, 2'd3, 1, 1, 0, 0, 1, 45, 0, 1, 1, 0, 44, 0};
        tv[27] = '{1, 1, 2'd0, 1, 1, 0, 0, 1, 46, 0, 1, 2, 0, 44, 0};
        tv[28] = '{1, 1, 2'd1, 0, 1, 1, 0, 1, 47, 0, 1, 2, 0, 45, 0};
        tv[29] = '{0, 1, 2'd1, 0, 1, 0, 0, 0, 47, 0, 1, 2, 0, 45, 0};
        tv[30] = '{0, 1, 2'd1, 0, 1, 0, 0, 1, 47, 0, 0, 0, 0, 0, 0};
        tv[31] = '{0, 1, 2'd1, 1, 1, 0, 0, 1, 47, 0, 0, 0, 0, 0, 0};
        tv[32] = '{1, 1, 2'd1, 0, 1, 0, 1, 1, 47, 1, 1, 1, 0, 47, 0};
        tv[33] = '{1, 1, 2'd1, 0, 1, 1, 1, 1, 47, 1, 0, 0, 0, 0, 0};
        tv[34] = '{0, 1, 2'd1, 0, 1, 0, 0, 1, 47, 1, 0, 0, 0, 0, 0};
        tv[35] = '{0, 1, 2'd1, 1, 1, 0, 1, 1, 47, 1, 0, 0, 0, 0, 0};
        tv[36] = '{1, 1, 2'd1, 0, 1, 0, 0, 1, 47, 0, 1, 1, 0, 47, 1};
        tv[37] = '{1, 1, 2'd1, 0, 1, 1, 0, 1, 47, 0, 0, 0, 0, 0, 0};

        reset = 1'b1; ce = 1'b0; mtr = 1'b0; stp = 2'd0; act = 1'b1;
        side_sel = 1'b0; we = 1'b0; img_mounted = 1'b0; save_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_htrack", int'(htrack), 36);
        check("rst_side", int'(side), 0);
        check("rst_tr00_n", int'(tr00_sense_n), 1);
        check("rst_save_req", int'(save_req), 0);
        check("rst_q_count", int'(q_count), 0);
        check("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            ce = tv[i].ce; mtr = tv[i].mtr; stp = tv[i].stp; we = tv[i].we;
            act = tv[i].act; save_ack = tv[i].ack; side_sel = tv[i].ss;
            img_mounted = tv[i].img;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_htrack", i), int'(htrack), tv[i].ht);
            check($sformatf("v%0d_side", i), int'(side), int'(tv[i].side));
            check($sformatf("v%0d_save_req", i), int'(save_req), int'(tv[i].req));
            check($sformatf("v%0d_q_count", i), int'(q_count), tv[i].qc);
            check($sformatf("v%0d_overflow", i), int'(overflow), int'(tv[i].ovf));
            if (tv[i].req) begin
                check($sformatf("v%0d_save_htrack", i), int'(save_htrack), tv[i].sht);
                check($sformatf("v%0d_save_side", i), int'(save_side), int'(tv[i].ssd));
            end
        end

        // Walk down to track 0 and past it, then up to the top and past it.
        cur_stp = 2'd1;
        for (int i = 0; i < 46; i++) do_step(2'd3, 1'b0);
        check("dn_htrack_1", int'(htrack), 1);
        check("dn_tr00_n_1", int'(tr00_sense_n), 1);
        do_step(2'd3, 1'b0);
        check("dn_htrack_0", int'(htrack), 0);
        check("dn_tr00_n_0", int'(tr00_sense_n), 0);
        do_step(2'd3, 1'b0);
        do_step(2'd3, 1'b0);
        check("dn_sat_htrack", int'(htrack), 0);
        check("dn_sat_tr00_n", int'(tr00_sense_n), 0);
        for (int i = 0; i < 84; i++) do_step(2'd1, 1'b0);
        check("up_htrack_84", int'(htrack), 84);
        check("up_tr00_n", int'(tr00_sense_n), 1);
        do_step(2'd1, 1'b0);
        do_step(2'd1, 1'b0);
        check("up_sat_htrack", int'(htrack), 84);
        check("sat_q_count", int'(q_count), 0);

        // Dirty at the top: a saturated step does not move, so no flush.
        do_step(2'd1, 1'b1);
        do_step(2'd1, 1'b0);
        check("sat_dirty_htrack", int'(htrack), 84);
        check("sat_dirty_no_req", int'(save_req), 0);
        do_step(2'd3, 1'b0);
        check("dn_flush_htrack", int'(htrack), 83);
        check("dn_flush_req", int'(save_req), 1);
        check("dn_flush_save_ht", int'(save_htrack), 84);

        // Async reset while a request is pending.
        @(negedge clk);
        ce = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_save_req", int'(save_req), 0);
        check("arst_q_count", int'(q_count), 0);
        check("arst_htrack", int'(htrack), 36);
        check("arst_tr00_n", int'(tr00_sense_n), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
